// File: rtl/alu_sub8s_if.sv
// Operand/result bundle between the 8085 ALU sequencer and the bit-serial subtractor.
// The master issues start with operands; the slave returns busy/done, result and flags.
interface alu_sub8s_if #(
  parameter int DATAW = 8
);
  logic             start;
  logic [DATAW-1:0] iA;
  logic [DATAW-1:0] iB;
  logic             iC;
  logic             busy;
  logic             done;
  logic [DATAW-1:0] oS;
  logic             oC;
  logic             oH;
  logic             oZ;
  logic             oN;
  logic             oP;

  modport master (
    output start, iA, iB, iC,
    input  busy, done, oS, oC, oH, oZ, oN, oP
  );

  modport slave (
    input  start, iA, iB, iC,
    output busy, done, oS, oC, oH, oZ, oN, oP
  );
endinterface

// File: rtl/alu_sub8s.sv
// Bit-serial subtractor: operands shift LSB-first through one difference/borrow cell,
// producing the difference word plus 8085 CY/AC/Z/S/P flags once all bits are processed.
module alu_sub8s #(
  parameter int DATAW = 8
) (
  input  logic        clk,
  input  logic        rstn,
  alu_sub8s_if.slave  bus
);
  localparam int CW = $clog2(DATAW);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [DATAW-1:0] r_a;
  logic [DATAW-1:0] r_b;
  logic [DATAW-1:0] r_res;
  logic [DATAW-1:0] r_s;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic             r_hTmp;
  logic             r_c;
  logic             r_h;
  logic             r_z;
  logic             r_n;
  logic             r_p;
  logic             w_load;
  logic             w_last;
  logic             w_d;
  logic             w_bo;
  logic [DATAW-1:0] w_resNext;

  assign w_load    = bus.start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last    = (r_state == SHIFT) && (r_cnt == CW'(DATAW - 1));
  assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
  assign w_bo      = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
  assign w_resNext = {w_d, r_res[DATAW-1:1]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = SHIFT;
      SHIFT:   if (w_last) w_next = DONE;
      DONE:    w_next = bus.start ? SHIFT : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Flags and result live in separate registers so partial sums never reach the outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_s    <= '0;
      r_cnt  <= '0;
      r_br   <= 1'b0;
      r_hTmp <= 1'b0;
      r_c    <= 1'b0;
      r_h    <= 1'b0;
      r_z    <= 1'b0;
      r_n    <= 1'b0;
      r_p    <= 1'b0;
    end else if (w_load) begin
      r_a   <= bus.iA;
      r_b   <= bus.iB;
      r_br  <= bus.iC;
      r_res <= '0;
      r_cnt <= '0;
    end else if (r_state == SHIFT) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_br  <= w_bo;
      r_res <= w_resNext;
      r_cnt <= r_cnt + CW'(1);
      if (r_cnt == CW'(3)) r_hTmp <= w_bo;
      if (w_last) begin
        r_s <= w_resNext;
        r_c <= w_bo;
        r_h <= r_hTmp;
        r_z <= (w_resNext == '0);
        r_n <= w_d;
        r_p <= ~^w_resNext;
      end
    end
  end

  assign bus.busy = (r_state == SHIFT);
  assign bus.done = (r_state == DONE);
  assign bus.oS   = r_s;
  assign bus.oC   = r_c;
  assign bus.oH   = r_h;
  assign bus.oZ   = r_z;
  assign bus.oN   = r_n;
  assign bus.oP   = r_p;
endmodule

// File: tb/tb_alu_sub8s.sv
// Randomized bench for alu_sub8s: an arithmetic reference model predicts handshake and
// flags every cycle, and a few hand-computed vectors pin that model down.
module tb_alu_sub8s;
  localparam int DATAW = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  alu_sub8s_if #(.DATAW(DATAW)) bus ();

  alu_sub8s #(.DATAW(DATAW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int         mLeft = 0;
  logic       mDone = 1'b0;
  logic [7:0] mS = '0;
  logic       mC = 1'b0, mH = 1'b0, mZ = 1'b0, mN = 1'b0, mP = 1'b0;
  logic [7:0] pS = '0;
  logic       pC = 1'b0, pH = 1'b0, pZ = 1'b0, pN = 1'b0, pP = 1'b0;

  // Model: an accepted start schedules a result DATAW edges later; results are plain arithmetic.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mLeft = 0;
      mDone = 1'b0;
      mS = '0; mC = 1'b0; mH = 1'b0; mZ = 1'b0; mN = 1'b0; mP = 1'b0;
    end else if (mLeft > 0) begin
      mLeft = mLeft - 1;
      if (mLeft == 0) begin
        mDone = 1'b1;
        mS = pS; mC = pC; mH = pH; mZ = pZ; mN = pN; mP = pP;
      end
    end else begin
      mDone = 1'b0;
      if (bus.start === 1'b1) begin
        int a, b, c;
        a  = int'(bus.iA);
        b  = int'(bus.iB);
        c  = int'(bus.iC);
        pS = 8'((a - b - c) & 255);
        pC = (a < b + c);
        pH = ((a % 16) < (b % 16) + c);
        pZ = (pS == 8'd0);
        pN = pS[7];
        pP = (($countones(pS) % 2) == 0);
        mLeft = DATAW;
      end
    end
  end

  always @(negedge clk) begin
    vectors++;
    if ({bus.busy, bus.done} !== {(mLeft > 0), mDone}) begin
      miscompares++;
      $display("[TB] FAIL handshake busy/done actual=%b%b required=%b%b at %0t",
               bus.busy, bus.done, (mLeft > 0), mDone, $time);
    end
    if ({bus.oS, bus.oC, bus.oH, bus.oZ, bus.oN, bus.oP} !== {mS, mC, mH, mZ, mN, mP}) begin
      miscompares++;
      $display("[TB] FAIL result oS=%h CHZNP=%b%b%b%b%b required oS=%h CHZNP=%b%b%b%b%b at %0t",
               bus.oS, bus.oC, bus.oH, bus.oZ, bus.oN, bus.oP,
               mS, mC, mH, mZ, mN, mP, $time);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic waitDone(input bit noise, output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 50) begin
      if (noise) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.iA    = 8'($urandom);
        bus.iB    = 8'($urandom);
        bus.iC    = 1'($urandom_range(0, 1));
      end
      tick();
      lat++;
    end
    bus.start = 1'b0;
    if (lat >= 50) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL done timeout actual=none required=pulse at %0t", $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c,
                               input bit noise, output int lat);
    bus.iA    = a;
    bus.iB    = b;
    bus.iC    = c;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.iA    = 8'($urandom);
    bus.iB    = 8'($urandom);
    bus.iC    = 1'($urandom_range(0, 1));
    waitDone(noise, lat);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] s, input logic c,
                             input logic h, input logic z, input logic n, input logic p,
                             input logic expDone);
    vectors++;
    if ({bus.busy, bus.done, bus.oS, bus.oC, bus.oH, bus.oZ, bus.oN, bus.oP}
        !== {1'b0, expDone, s, c, h, z, n, p}) begin
      miscompares++;
      $display("[TB] FAIL %s busy/done=%b%b oS=%h CHZNP=%b%b%b%b%b required busy/done=0%b oS=%h CHZNP=%b%b%b%b%b",
               name, bus.busy, bus.done, bus.oS, bus.oC, bus.oH, bus.oZ, bus.oN, bus.oP,
               expDone, s, c, h, z, n, p);
    end
  endtask

  task automatic checkLatency(input string name, input int lat);
    vectors++;
    if (lat != DATAW) begin
      miscompares++;
      $display("[TB] FAIL %s latency actual=%0d required=%0d", name, lat, DATAW);
    end
  endtask

  initial begin
    int lat;
    bus.start = 1'b0;
    bus.iA    = '0;
    bus.iB    = '0;
    bus.iC    = 1'b0;
    tick();
    tick();
    checkOutput("reset held", 8'h00, 0, 0, 0, 0, 0, 1'b0);
    rstn = 1'b1;
    tick();
    checkOutput("reset released", 8'h00, 0, 0, 0, 0, 0, 1'b0);

    applyStimulus(8'h05, 8'h03, 1'b0, 1'b0, lat);
    checkLatency("05-03", lat);
    checkOutput("05-03", 8'h02, 0, 0, 0, 0, 0, 1'b1);
    tick();

    applyStimulus(8'h00, 8'h01, 1'b0, 1'b0, lat);
    checkOutput("00-01", 8'hFF, 1, 1, 0, 1, 1, 1'b1);
    tick();

    applyStimulus(8'h10, 8'h01, 1'b0, 1'b0, lat);
    checkOutput("10-01", 8'h0F, 0, 1, 0, 0, 1, 1'b1);
    tick();

    // Second start three cycles into SHIFT must be ignored.
    bus.iA = 8'h42; bus.iB = 8'h41; bus.iC = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.iA = 8'hFF; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    waitDone(1'b0, lat);
    checkLatency("42-41-1 with ignored start", lat + 3);
    checkOutput("42-41-1", 8'h00, 0, 0, 1, 0, 1, 1'b1);

    applyStimulus(8'h80, 8'h01, 1'b0, 1'b0, lat);
    checkLatency("80-01 back-to-back", lat);
    checkOutput("80-01", 8'h7F, 0, 1, 0, 0, 0, 1'b1);
    tick();

    bus.iA = 8'h33; bus.iB = 8'h11; bus.iC = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    rstn = 1'b0;
    #1;
    checkOutput("reset mid-shift", 8'h00, 0, 0, 0, 0, 0, 1'b0);
    tick();
    rstn = 1'b1;
    repeat (12) tick();
    applyStimulus(8'h33, 8'h11, 1'b0, 1'b0, lat);
    checkOutput("33-11 after reset", 8'h22, 0, 0, 0, 0, 1, 1'b1);
    tick();

    for (int i = 0; i < 150; i++) begin
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1, lat);
      if ($urandom_range(0, 2) != 0) tick();
      if ($urandom_range(0, 1) != 0) tick();
    end
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
